// File: rtl/timer_pkg.sv
// timer_pkg: shared types and constants for the timer clock/reset block.
// FSM state enum, default prescaler/hold sizes, select-width helper.
package timer_pkg;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_RST_HOLD = 4;
  localparam int HOLD_W       = 8;

  typedef enum logic [0:0] {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int sel_w_f(input int cnt_w);
    return ($clog2(cnt_w) < 1) ? 1 : $clog2(cnt_w);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: one divided clock-enable channel off the shared prescaler.
// In: pclk, preset, presc, sel, run. Out: tick (registered 1-cycle pulse).
module tick_gen
  import timer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int SEL_W = sel_w_f(DEF_CNT_W)
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic [CNT_W-1:0] presc,
  input  logic [SEL_W-1:0] sel,
  input  logic             run,
  output logic             tick
);

  localparam logic [31:0] MAX_SEL = 32'(CNT_W - 1);

  logic [31:0]      sel_x;
  logic [31:0]      sel_c;
  logic [CNT_W-1:0] mask;
  logic             hit;

  // Selects past the prescaler width saturate at the slowest ratio.
  always_comb begin
    sel_x = 32'(sel);
    sel_c = (sel_x > MAX_SEL) ? MAX_SEL : sel_x;
  end

  // Low (sel+1) bits of the prescaler take part in the terminal match.
  always_comb begin
    mask = '0;
    for (int b = 0; b < CNT_W; b++) begin
      mask[b] = (32'(b) <= sel_c);
    end
  end

  assign hit = run && ((presc & mask) == mask);

  always_ff @(posedge pclk) begin
    if (preset) begin
      tick <= 1'b0;
    end else begin
      tick <= hit;
    end
  end

endmodule

// File: rtl/clk_div_rst_seq.sv
// clk_div_rst_seq: prescaler, per-channel tick enables, reset stretcher.
// In: pclk, preset, en, sw_rst, div_sel. Out: tick, rst_out, busy.
module clk_div_rst_seq
  import timer_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int NUM_CH   = 4,
  parameter int SEL_W    = sel_w_f(CNT_W),
  parameter int RST_HOLD = DEF_RST_HOLD
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    en,
  input  logic                    sw_rst,
  input  logic [NUM_CH*SEL_W-1:0] div_sel,
  output logic [NUM_CH-1:0]       tick,
  output logic                    rst_out,
  output logic                    busy
);

  localparam logic [HOLD_W-1:0] HOLD_LD  = HOLD_W'(RST_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t            state;
  state_t            state_nx;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nx;
  logic [CNT_W-1:0]  presc;
  logic [CNT_W-1:0]  presc_nx;
  logic              run;

  // run also drops on the sw_rst cycle so no tick leaks into HOLD.
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    presc_nx = presc;
    run      = 1'b0;
    unique case (state)
      ST_HOLD: begin
        if (sw_rst) begin
          hold_nx = HOLD_LD;
        end else if (hold_cnt == '0) begin
          state_nx = ST_RUN;
        end else begin
          hold_nx = hold_cnt - HOLD_ONE;
        end
      end
      ST_RUN: begin
        if (sw_rst) begin
          state_nx = ST_HOLD;
          hold_nx  = HOLD_LD;
          presc_nx = '0;
        end else if (en) begin
          run      = 1'b1;
          presc_nx = presc + CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= ST_HOLD;
      hold_cnt <= HOLD_LD;
      presc    <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      presc    <= presc_nx;
    end
  end

  assign rst_out = (state == ST_HOLD);
  assign busy    = rst_out;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_gen #(
      .CNT_W (CNT_W),
      .SEL_W (SEL_W)
    ) u_tick (
      .pclk   (pclk),
      .preset (preset),
      .presc  (presc),
      .sel    (div_sel[i*SEL_W +: SEL_W]),
      .run    (run),
      .tick   (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_rst_seq.sv
// tb_clk_div_rst_seq: scoreboard bench for clk_div_rst_seq.
// Driver queues per-cycle expectations; monitor pops and compares.
module tb_clk_div_rst_seq;

  logic        pclk = 1'b0;
  logic        preset;
  logic        en;
  logic        sw_rst;
  logic [15:0] div_sel;
  logic [3:0]  tick;
  logic        rst_out;
  logic        busy;

  typedef struct {
    logic       r;
    logic [3:0] t;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n        = 0;
  int   per[4];

  always #5 pclk = ~pclk;

  clk_div_rst_seq #(
    .CNT_W    (8),
    .NUM_CH   (4),
    .SEL_W    (4),
    .RST_HOLD (4)
  ) dut (
    .pclk    (pclk),
    .preset  (preset),
    .en      (en),
    .sw_rst  (sw_rst),
    .div_sel (div_sel),
    .tick    (tick),
    .rst_out (rst_out),
    .busy    (busy)
  );

  always @(negedge pclk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if ({rst_out, busy, tick} !== {x.r, x.r, x.t}) begin
        failures++;
        $display("FAIL %s t=%0t: got rst=%b busy=%b tick=%b want rst=%b busy=%b tick=%b",
                 x.nm, $time, rst_out, busy, tick, x.r, x.r, x.t);
      end
    end
  end

  task automatic cyc(input bit e, input bit s, input bit p,
                     input bit xr, input logic [3:0] xt,
                     input string nm);
    en     = e;
    sw_rst = s;
    preset = p;
    @(posedge pclk);
    #1;
    q.push_back('{r: xr, t: xt, nm: nm});
    @(negedge pclk);
  endtask

  task automatic hold_tail(input int cnt, input string nm);
    for (int k = 0; k < cnt; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0, nm);
    end
  endtask

  task automatic release_run(input string nm);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, nm);
    n = 0;
  endtask

  task automatic run_n(input int cnt, input bit e, input string nm);
    logic [3:0] xt;
    for (int k = 0; k < cnt; k++) begin
      if (e) n++;
      for (int i = 0; i < 4; i++) begin
        xt[i] = e && (n % per[i] == 0);
      end
      cyc(e, 1'b0, 1'b0, 1'b0, xt, nm);
    end
  endtask

  initial begin
    div_sel = 16'h7210;
    per[0] = 2;
    per[1] = 4;
    per[2] = 8;
    per[3] = 256;

    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'b0, "por_reset");
    end
    hold_tail(3, "por_hold");
    release_run("por_release");

    run_n(512, 1'b1, "divide");

    run_n(4, 1'b1, "pre_gap");
    run_n(5, 1'b0, "en_gap");
    run_n(20, 1'b1, "post_gap");

    run_n(3, 1'b1, "pre_sw");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'b0, "sw_rst");
    hold_tail(3, "sw_hold");
    release_run("sw_release");
    run_n(20, 1'b1, "after_sw");

    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'b0, "sw2_first");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0, "sw2_hold");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'b0, "sw2_second");
    hold_tail(3, "sw2_ext_hold");
    release_run("sw2_release");
    run_n(10, 1'b1, "after_sw2");

    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'b0, "sw_en0");
    hold_tail(3, "sw_en0_hold");
    release_run("sw_en0_release");
    run_n(10, 1'b1, "after_sw_en0");

    div_sel = 16'h93F8;
    per[0] = 256;
    per[1] = 256;
    per[2] = 16;
    per[3] = 256;
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'b0, "clamp_reset");
    hold_tail(3, "clamp_hold");
    release_run("clamp_release");
    run_n(300, 1'b1, "clamp");

    run_n(5, 1'b1, "pre_prio");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'b0, "prio_both");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'b0, "prio_both");
    hold_tail(3, "prio_hold");
    release_run("prio_release");
    run_n(40, 1'b1, "prio_run");

    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
